excit_period_seq: RTL and testbench
===================================

// Module: excit_period_seq
// PURPOSE
//  Parametrised excitation/sample sequencer for the ECT front end; successor to the single-channel hold-zero counter.
//  Counts Sync ticks into measurement periods and steps the excitation channel index across NUM_CH electrodes.
//  Generates sample windows, per-channel and per-frame strobes, and an optional DDS hold-at-zero slot.
//  Sits between the DDS core and the ADC/electrode-switch control.
// PARAMETERS
//  DW          14  DDS sample width (offset binary; ZERO = 1<<(DW-1))
//  CNT_W        8  periodCnt width
//  PERIOD       9  last periodCnt value; one period = PERIOD+1 Sync ticks
//  ZERO_SLOTS   1  ticks at period start treated as zero slots (periodCnt < ZERO_SLOTS)
//  SAMPLE_START 2  first periodCnt value of the sample window
//  SAMPLE_LEN   4  sample window length in ticks
//  NUM_CH      12  excitation channels per frame
//  CH_W         4  chIdx width, 2**CH_W >= NUM_CH
//  Elaboration error if SAMPLE_START+SAMPLE_LEN-1 > PERIOD, ZERO_SLOTS > SAMPLE_START, or PERIOD >= 2**CNT_W.
// PORTS
//  Clk        in   1      system clock, all logic rising-edge
//  Rst        in   1      reset, asynchronous, active-low
//  Sync       in   1      one-Clk tick pulse, synchronous to Clk
//  EnExcit    in   1      excitation enable (level)
//  DDSIn      in   DW     DDS sine sample
//  DDSOut     out  DW     DDS sample to DAC, registered
//  periodCnt  out  CNT_W  tick position in current period
//  chIdx      out  CH_W   current excitation channel
//  sampleEn   out  1      high while periodCnt in sample window, RUN only
//  chAdvance  out  1      one-Clk pulse on channel step
//  frameDone  out  1      one-Clk pulse when chIdx wraps NUM_CH-1 -> 0
//  busy       out  1      high in RUN or DRAIN
// BEHAVIOUR
//  Reset: state IDLE, periodCnt 0, chIdx 0, sampleEn/chAdvance/frameDone/busy 0, DDSOut ZERO.
//  FSM states IDLE, RUN, DRAIN; all outputs registered.
//  IDLE: counters held 0; EnExcit=1 -> RUN next Clk; Sync ignored in IDLE.
//  RUN, Sync=1: periodCnt==PERIOD -> periodCnt 0, chAdvance=1, chIdx+1 (NUM_CH-1 wraps to 0 with frameDone=1); else periodCnt+1.
//  RUN, EnExcit=0 -> DRAIN; a Sync in the same Clk still advances the counters.
//  DRAIN: Sync advances periodCnt only; Sync at periodCnt==PERIOD -> IDLE, periodCnt 0, chIdx 0.
//  DRAIN: no chAdvance, no frameDone, and sampleEn forced 0.
//  DRAIN, EnExcit=1 -> RUN with counters kept (no restart).
//  sampleEn = (RUN) && SAMPLE_START <= next periodCnt <= SAMPLE_START+SAMPLE_LEN-1, aligned with periodCnt.
//  chAdvance/frameDone are exactly one Clk wide, coincident with periodCnt returning to 0.
//  Asynchronous Rst mid-period: immediate return to reset values; no strobe is emitted.
//  NUM_CH=1: chIdx stays 0 and frameDone pulses with every chAdvance.
// CONFIGURATION
//  HOLD_ZERO_EN defined:
//   - DDSOut <= ZERO when state==IDLE or periodCnt < ZERO_SLOTS; else DDSOut <= DDSIn.
//   - In DRAIN, zero slots apply the same way.
//  HOLD_ZERO_EN undefined: DDSOut <= DDSIn at all times, including IDLE; 1 Clk latency.
// TESTING
//  1. Rst low, drive DDSIn=14'h1234 -> all outputs at reset values, DDSOut=14'h2000.
//  2. EnExcit=1, 10 Syncs (default params) -> periodCnt 0..9, then 0.
//     - sampleEn high for periodCnt 2..5.
//     - chAdvance single pulse; chIdx 0->1.
//  3. EnExcit=1, 120 Syncs -> 12 chAdvance pulses and one frameDone, coincident with chIdx 11->0.
//  4. EnExcit 1->0 at periodCnt=4, ch 3 -> DRAIN with sampleEn=0.
//     - IDLE after Sync at periodCnt=9; chIdx=0.
//     - no chAdvance; busy falls same Clk.
//  5. Drain re-enable: drop EnExcit at periodCnt=4, reassert at periodCnt=6 -> RUN resumes at 6/ch same.
//     - next period boundary gives chAdvance.
//  6. HOLD_ZERO_EN defined, DDSIn=14'h3FFF -> DDSOut=14'h2000 in IDLE and at periodCnt 0; 14'h3FFF elsewhere.
//     - undefined -> always 14'h3FFF after 1 Clk.
//  7. Rst asserted at periodCnt=7 -> immediate reset values; first Sync after release with EnExcit=1 yields periodCnt=1.

Source files
------------

// File: rtl/excit_period_seq_if.sv
// excit_period_seq_if: handshake, DDS data and status signals of the excitation/sample sequencer.
interface excit_period_seq_if #(
    parameter int DW    = 14,
    parameter int CNT_W = 8,
    parameter int CH_W  = 4
) ();
    logic             Sync;
    logic             EnExcit;
    logic [DW-1:0]    DDSIn;
    logic [DW-1:0]    DDSOut;
    logic [CNT_W-1:0] periodCnt;
    logic [CH_W-1:0]  chIdx;
    logic             sampleEn;
    logic             chAdvance;
    logic             frameDone;
    logic             busy;

    modport master (
        output Sync, EnExcit, DDSIn,
        input  DDSOut, periodCnt, chIdx, sampleEn, chAdvance, frameDone, busy
    );

    modport slave (
        input  Sync, EnExcit, DDSIn,
        output DDSOut, periodCnt, chIdx, sampleEn, chAdvance, frameDone, busy
    );
endinterface

// File: rtl/excit_period_seq.sv
// excit_period_seq: counts Sync ticks into periods, steps the excitation channel and emits sample window/strobes.
// Define HOLD_ZERO_EN to hold DDSOut at mid-scale in IDLE and during the leading zero slots of each period.
module excit_period_seq #(
    parameter int DW           = 14,
    parameter int CNT_W        = 8,
    parameter int PERIOD       = 9,
    parameter int ZERO_SLOTS   = 1,
    parameter int SAMPLE_START = 2,
    parameter int SAMPLE_LEN   = 4,
    parameter int NUM_CH       = 12,
    parameter int CH_W         = 4
) (
    input logic               Clk,
    input logic               Rst,
    excit_period_seq_if.slave bus
);
    localparam logic [DW-1:0]    ZERO     = DW'(1) << (DW - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] ZS       = CNT_W'(ZERO_SLOTS);
    localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(SAMPLE_START);
    localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(SAMPLE_START + SAMPLE_LEN - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    generate
        if (SAMPLE_START + SAMPLE_LEN - 1 > PERIOD || ZERO_SLOTS > SAMPLE_START ||
            PERIOD >= 2 ** CNT_W || NUM_CH > 2 ** CH_W || NUM_CH < 1) begin : g_bad_params
            $error("excit_period_seq: inconsistent parameters");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt_n;
    logic [CH_W-1:0]  ch_n;
    logic             adv_n, frame_n, win_n, wrap;
    logic [DW-1:0]    dds_n;

    assign wrap = bus.periodCnt == LAST_CNT;

    always_comb begin
        state_n = state;
        cnt_n   = bus.periodCnt;
        ch_n    = bus.chIdx;
        adv_n   = 1'b0;
        frame_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                ch_n    = '0;
                state_n = bus.EnExcit ? RUN : IDLE;
            end
            RUN: begin
                if (bus.Sync) begin
                    cnt_n   = wrap ? '0 : bus.periodCnt + 1'b1;
                    adv_n   = wrap;
                    frame_n = wrap && bus.chIdx == LAST_CH;
                    ch_n    = !wrap ? bus.chIdx : frame_n ? '0 : bus.chIdx + 1'b1;
                end
                state_n = bus.EnExcit ? RUN : DRAIN;
            end
            default: begin
                // Draining finishes the period silently; re-enable resumes RUN where it stands
                if (bus.Sync)
                    cnt_n = wrap ? '0 : bus.periodCnt + 1'b1;
                if (bus.Sync && wrap && !bus.EnExcit) begin
                    ch_n    = '0;
                    state_n = IDLE;
                end else begin
                    state_n = bus.EnExcit ? RUN : DRAIN;
                end
            end
        endcase
    end

    assign win_n = state_n == RUN && cnt_n >= WIN_LO && cnt_n <= WIN_HI;

`ifdef HOLD_ZERO_EN
    assign dds_n = (state_n == IDLE || cnt_n < ZS) ? ZERO : bus.DDSIn;
`else
    assign dds_n = bus.DDSIn;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= IDLE;
            bus.periodCnt <= '0;
            bus.chIdx     <= '0;
            bus.sampleEn  <= 1'b0;
            bus.chAdvance <= 1'b0;
            bus.frameDone <= 1'b0;
            bus.busy      <= 1'b0;
            bus.DDSOut    <= ZERO;
        end else begin
            state         <= state_n;
            bus.periodCnt <= cnt_n;
            bus.chIdx     <= ch_n;
            bus.sampleEn  <= win_n;
            bus.chAdvance <= adv_n;
            bus.frameDone <= frame_n;
            bus.busy      <= state_n != IDLE;
            bus.DDSOut    <= dds_n;
        end
    end
endmodule

// File: tb/tb_excit_period_seq.sv
// tb_excit_period_seq: directed bench for excit_period_seq with default parameters.
// Expected DDSOut values follow HOLD_ZERO_EN when it is defined for the build.
module tb_excit_period_seq;
`ifdef HOLD_ZERO_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic Clk, Rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    excit_period_seq_if bus ();
    excit_period_seq dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step(input logic s);
        bus.Sync = s;
        @(posedge Clk);
        #1;
        bus.Sync = 1'b0;
    endtask

    task automatic do_reset();
        bus.Sync    = 1'b0;
        bus.EnExcit = 1'b0;
        Rst         = 1'b0;
        #2;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
    endtask

    task automatic run_to(input int n);
        bus.EnExcit = 1'b1;
        step(1'b0);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic test_reset();
        bus.DDSIn   = 14'h1234;
        bus.EnExcit = 1'b0;
        bus.Sync    = 1'b0;
        Rst         = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        bus.EnExcit = 1'b1;
        bus.Sync    = 1'b1;
        @(posedge Clk);
        #1;
        n_cmp++; if (bus.periodCnt !== 8'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", bus.periodCnt); end
        n_cmp++; if (bus.chIdx !== 4'd0) begin n_bad++; $display("FAIL rst_ch: got %0d want 0", bus.chIdx); end
        n_cmp++; if (bus.sampleEn !== 1'b0) begin n_bad++; $display("FAIL rst_sample: got %b want 0", bus.sampleEn); end
        n_cmp++; if (bus.chAdvance !== 1'b0) begin n_bad++; $display("FAIL rst_adv: got %b want 0", bus.chAdvance); end
        n_cmp++; if (bus.frameDone !== 1'b0) begin n_bad++; $display("FAIL rst_frame: got %b want 0", bus.frameDone); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.DDSOut !== 14'h2000) begin n_bad++; $display("FAIL rst_dds: got %h want 2000", bus.DDSOut); end
        bus.Sync    = 1'b0;
        bus.EnExcit = 1'b0;
        Rst         = 1'b1;
        step(1'b1);
        n_cmp++; if (bus.busy !== 1'b0 || bus.periodCnt !== 8'd0) begin n_bad++; $display("FAIL idle_hold: got busy=%b cnt=%0d want busy=0 cnt=0", bus.busy, bus.periodCnt); end
        n_cmp++; if (bus.DDSOut !== (HZ ? 14'h2000 : 14'h1234)) begin n_bad++; $display("FAIL idle_dds: got %h want %h", bus.DDSOut, HZ ? 14'h2000 : 14'h1234); end
    endtask

    task automatic test_period();
        int exp_cnt;
        do_reset();
        run_to(0);
        n_cmp++; if (bus.busy !== 1'b1 || bus.periodCnt !== 8'd0) begin n_bad++; $display("FAIL run_entry: got busy=%b cnt=%0d want busy=1 cnt=0", bus.busy, bus.periodCnt); end
        for (int i = 1; i <= 10; i++) begin
            step(1'b1);
            exp_cnt = i % 10;
            n_cmp++; if (bus.periodCnt !== 8'(exp_cnt)) begin n_bad++; $display("FAIL per_cnt%0d: got %0d want %0d", i, bus.periodCnt, exp_cnt); end
            n_cmp++; if (bus.sampleEn !== (exp_cnt >= 2 && exp_cnt <= 5)) begin n_bad++; $display("FAIL per_sample%0d: got %b want %b", i, bus.sampleEn, exp_cnt >= 2 && exp_cnt <= 5); end
            n_cmp++; if (bus.chAdvance !== (i == 10)) begin n_bad++; $display("FAIL per_adv%0d: got %b want %b", i, bus.chAdvance, i == 10); end
            n_cmp++; if (bus.chIdx !== (i == 10 ? 4'd1 : 4'd0)) begin n_bad++; $display("FAIL per_ch%0d: got %0d want %0d", i, bus.chIdx, i == 10 ? 1 : 0); end
        end
        step(1'b0);
        n_cmp++; if (bus.chAdvance !== 1'b0 || bus.chIdx !== 4'd1 || bus.periodCnt !== 8'd0) begin n_bad++; $display("FAIL per_hold: got adv=%b ch=%0d cnt=%0d want adv=0 ch=1 cnt=0", bus.chAdvance, bus.chIdx, bus.periodCnt); end
    endtask

    task automatic test_frame();
        int adv = 0, frm = 0;
        logic [3:0] prev_ch = 4'd0;
        do_reset();
        run_to(0);
        for (int i = 1; i <= 120; i++) begin
            step(1'b1);
            if (bus.chAdvance === 1'b1) adv++;
            if (bus.frameDone === 1'b1) begin
                frm++;
                n_cmp++; if (bus.chIdx !== 4'd0 || prev_ch !== 4'd11 || bus.chAdvance !== 1'b1 || i != 120) begin n_bad++; $display("FAIL frame_wrap: got ch=%0d prev=%0d adv=%b sync=%0d want ch=0 prev=11 adv=1 sync=120", bus.chIdx, prev_ch, bus.chAdvance, i); end
            end
            prev_ch = bus.chIdx;
        end
        n_cmp++; if (adv != 12) begin n_bad++; $display("FAIL frame_adv_count: got %0d want 12", adv); end
        n_cmp++; if (frm != 1) begin n_bad++; $display("FAIL frame_done_count: got %0d want 1", frm); end
        n_cmp++; if (bus.chIdx !== 4'd0 || bus.periodCnt !== 8'd0) begin n_bad++; $display("FAIL frame_end: got ch=%0d cnt=%0d want ch=0 cnt=0", bus.chIdx, bus.periodCnt); end
    endtask

    task automatic test_drain();
        do_reset();
        run_to(34);
        n_cmp++; if (bus.chIdx !== 4'd3 || bus.periodCnt !== 8'd4 || bus.sampleEn !== 1'b1) begin n_bad++; $display("FAIL drain_pre: got ch=%0d cnt=%0d smp=%b want ch=3 cnt=4 smp=1", bus.chIdx, bus.periodCnt, bus.sampleEn); end
        bus.EnExcit = 1'b0;
        step(1'b0);
        n_cmp++; if (bus.busy !== 1'b1 || bus.sampleEn !== 1'b0 || bus.periodCnt !== 8'd4) begin n_bad++; $display("FAIL drain_entry: got busy=%b smp=%b cnt=%0d want busy=1 smp=0 cnt=4", bus.busy, bus.sampleEn, bus.periodCnt); end
        for (int i = 5; i <= 9; i++) begin
            step(1'b1);
            n_cmp++; if (bus.periodCnt !== 8'(i) || bus.sampleEn !== 1'b0 || bus.chAdvance !== 1'b0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL drain_cnt%0d: got cnt=%0d smp=%b adv=%b busy=%b want cnt=%0d smp=0 adv=0 busy=1", i, bus.periodCnt, bus.sampleEn, bus.chAdvance, bus.busy, i); end
        end
        step(1'b1);
        n_cmp++; if (bus.busy !== 1'b0 || bus.chIdx !== 4'd0 || bus.periodCnt !== 8'd0) begin n_bad++; $display("FAIL drain_idle: got busy=%b ch=%0d cnt=%0d want busy=0 ch=0 cnt=0", bus.busy, bus.chIdx, bus.periodCnt); end
        n_cmp++; if (bus.chAdvance !== 1'b0 || bus.frameDone !== 1'b0) begin n_bad++; $display("FAIL drain_strobe: got adv=%b frm=%b want 0 0", bus.chAdvance, bus.frameDone); end
        step(1'b1);
        n_cmp++; if (bus.periodCnt !== 8'd0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_sync: got cnt=%0d busy=%b want 0 0", bus.periodCnt, bus.busy); end
    endtask

    task automatic test_back_to_run();
        do_reset();
        run_to(34);
        bus.EnExcit = 1'b0;
        step(1'b0);
        step(1'b1);
        step(1'b1);
        n_cmp++; if (bus.periodCnt !== 8'd6 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL redrain_cnt: got cnt=%0d busy=%b want 6 1", bus.periodCnt, bus.busy); end
        bus.EnExcit = 1'b1;
        step(1'b0);
        n_cmp++; if (bus.periodCnt !== 8'd6 || bus.chIdx !== 4'd3 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL resume: got cnt=%0d ch=%0d busy=%b want 6 3 1", bus.periodCnt, bus.chIdx, bus.busy); end
        repeat (3) step(1'b1);
        n_cmp++; if (bus.periodCnt !== 8'd9 || bus.chAdvance !== 1'b0) begin n_bad++; $display("FAIL resume_cnt: got cnt=%0d adv=%b want 9 0", bus.periodCnt, bus.chAdvance); end
        step(1'b1);
        n_cmp++; if (bus.chAdvance !== 1'b1 || bus.chIdx !== 4'd4 || bus.periodCnt !== 8'd0) begin n_bad++; $display("FAIL resume_adv: got adv=%b ch=%0d cnt=%0d want 1 4 0", bus.chAdvance, bus.chIdx, bus.periodCnt); end
    endtask

    task automatic test_dds();
        bus.DDSIn = 14'h3FFF;
        do_reset();
        step(1'b0);
        n_cmp++; if (bus.DDSOut !== (HZ ? 14'h2000 : 14'h3FFF)) begin n_bad++; $display("FAIL dds_idle: got %h want %h", bus.DDSOut, HZ ? 14'h2000 : 14'h3FFF); end
        run_to(0);
        n_cmp++; if (bus.DDSOut !== (HZ ? 14'h2000 : 14'h3FFF)) begin n_bad++; $display("FAIL dds_slot0: got %h want %h", bus.DDSOut, HZ ? 14'h2000 : 14'h3FFF); end
        step(1'b1);
        n_cmp++; if (bus.DDSOut !== 14'h3FFF) begin n_bad++; $display("FAIL dds_slot1: got %h want 3fff", bus.DDSOut); end
        bus.DDSIn = 14'h0ABC;
        n_cmp++; if (bus.DDSOut !== 14'h3FFF) begin n_bad++; $display("FAIL dds_latency: got %h want 3fff", bus.DDSOut); end
        step(1'b0);
        n_cmp++; if (bus.DDSOut !== 14'h0ABC) begin n_bad++; $display("FAIL dds_follow: got %h want 0abc", bus.DDSOut); end
        repeat (9) step(1'b1);
        n_cmp++; if (bus.periodCnt !== 8'd0 || bus.DDSOut !== (HZ ? 14'h2000 : 14'h0ABC)) begin n_bad++; $display("FAIL dds_wrap: got cnt=%0d dds=%h want cnt=0 dds=%h", bus.periodCnt, bus.DDSOut, HZ ? 14'h2000 : 14'h0ABC); end
    endtask

    task automatic test_async_reset();
        bus.DDSIn = 14'h1111;
        do_reset();
        run_to(7);
        n_cmp++; if (bus.periodCnt !== 8'd7) begin n_bad++; $display("FAIL arst_pre: got %0d want 7", bus.periodCnt); end
        #2;
        Rst = 1'b0;
        #1;
        n_cmp++; if (bus.periodCnt !== 8'd0 || bus.busy !== 1'b0 || bus.chIdx !== 4'd0 || bus.sampleEn !== 1'b0) begin n_bad++; $display("FAIL arst_now: got cnt=%0d busy=%b ch=%0d smp=%b want 0 0 0 0", bus.periodCnt, bus.busy, bus.chIdx, bus.sampleEn); end
        n_cmp++; if (bus.DDSOut !== 14'h2000 || bus.chAdvance !== 1'b0 || bus.frameDone !== 1'b0) begin n_bad++; $display("FAIL arst_out: got dds=%h adv=%b frm=%b want 2000 0 0", bus.DDSOut, bus.chAdvance, bus.frameDone); end
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        step(1'b0);
        step(1'b1);
        n_cmp++; if (bus.periodCnt !== 8'd1 || bus.busy !== 1'b1 || bus.chAdvance !== 1'b0) begin n_bad++; $display("FAIL arst_restart: got cnt=%0d busy=%b adv=%b want 1 1 0", bus.periodCnt, bus.busy, bus.chAdvance); end
    endtask

    initial begin
        test_reset();
        test_period();
        test_frame();
        test_drain();
        test_back_to_run();
        test_dds();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
